rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter giving two requesters shared, one-at-a-time reads of an 8-entry one-hot ROM.
// Latency: response valid LAT+2 cycles after the accept cycle; one transaction per LAT+3 cycles back-to-back.
// Backpressure: the response is held in RESP until rsp_ready; new requests wait (ready low) until back in IDLE.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   reqN_valid / reqN_idx        read request from requester N (entry 0..7)
//   reqN_ready                   combinational grant, only ever high in IDLE
//   rom_en / rom_address         one-cycle ROM enable with one-hot select (idx 0 -> 8'h80)
//   rom_data                     registered ROM output, valid LAT cycles after the issue edge
//   rsp_valid/rsp_id/rsp_data    response to the owning requester, stable until rsp_ready
//   busy                         high whenever a transaction is in flight
module rom_arbiter #(
  parameter int LAT = 1  // ROM read latency, 1..4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_idx,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_idx,
  output logic       req1_ready,
  output logic       rom_en,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WAIT lasts LAT cycles; the counter runs LAT-1 down to 0 and the ROM word
  // is captured on the cycle it reads 0.
  localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;  // requester granted most recently
  logic [2:0] idx_q;       // index latched at accept; later idx changes are ignored
  logic       id_q;        // owner of the transaction in flight
  logic [1:0] cnt;
  logic [7:0] data_q;

  logic       grant_id;
  logic       accept;

  always_comb begin
    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end

    state_nxt   = state;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rom_en      = 1'b0;
    rom_address = 8'h00;
    rsp_valid   = 1'b0;
    busy        = 1'b0;

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        busy        = 1'b1;
        rom_en      = 1'b1;
        rom_address = 8'h80 >> idx_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 2'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset cycle, whatever state we
    // happen to be leaving, so nothing downstream sees a half-abandoned read.
    if (rst) begin
      accept      = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rom_en      = 1'b0;
      rom_address = 8'h00;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;  // requester 0 wins the first tie
      cnt        <= 2'd0;
      data_q     <= 8'h00;
      id_q       <= 1'b0;
      idx_q      <= 3'd0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        idx_q      <= grant_id ? req1_idx : req0_idx;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end

      if (state == ISSUE) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end

      if (state == WAIT && cnt == 2'd0) begin
        data_q <= rom_data;
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;

endmodule
